// File: rtl/wb_openram_pkg.sv
// Shared types and helpers for the Wishbone-to-OpenRAM bridge.
// The optional error response is enabled with the WB_OPENRAM_ERR_EN macro (see wb_openram_ctrl).
package wb_openram_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StAck
  } state_e;

  localparam logic [31:0] DefaultBaseAddr    = 32'h3000_0000;
  localparam int unsigned DefaultAddrWidth   = 8;
  localparam int unsigned DefaultWindowBytes = 4 << DefaultAddrWidth;
  localparam int unsigned LatCntWidth        = 2;

  function automatic int unsigned window_bytes(input int unsigned addr_width);
    return 4 << addr_width;
  endfunction

  // 33-bit compare so a window ending at 4 GiB does not wrap.
  function automatic logic window_hit(input logic [31:0] adr, input logic [31:0] base,
                                      input int unsigned addr_width);
    logic [32:0] lo;
    logic [32:0] hi;
    lo = {1'b0, base};
    hi = lo + 33'(window_bytes(addr_width));
    return ({1'b0, adr} >= lo) && ({1'b0, adr} < hi);
  endfunction

endpackage

// File: rtl/wb_openram_adr_dec.sv
// Window decode for the OpenRAM bridge: qualified hit and word address of the macro.
module wb_openram_adr_dec
  import wb_openram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = DefaultBaseAddr,
  parameter int unsigned ADDR_WIDTH = DefaultAddrWidth
) (
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic [31:0]           adr_i,
  output logic                  hit_o,
  output logic [ADDR_WIDTH-1:0] word_adr_o
);

  assign hit_o      = cyc_i & stb_i & window_hit(adr_i, BASE_ADDR, ADDR_WIDTH);
  assign word_adr_o = adr_i[ADDR_WIDTH+1:2];

endmodule

// File: rtl/wb_openram_ctrl.sv
// Wishbone classic slave driving the 1rw port of one OpenRAM macro; all outputs registered.
// Define WB_OPENRAM_ERR_EN to add wbs_err_o, a one-cycle error response to out-of-window requests.
module wb_openram_ctrl
  import wb_openram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = DefaultBaseAddr,
  parameter int unsigned ADDR_WIDTH   = DefaultAddrWidth,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
`ifdef WB_OPENRAM_ERR_EN
  output logic                  wbs_err_o,
`endif
  output logic [31:0]           wbs_dat_o,
  output logic                  ram_csb0_o,
  output logic                  ram_web0_o,
  output logic [3:0]            ram_wmask0_o,
  output logic [ADDR_WIDTH-1:0] ram_addr0_o,
  output logic [31:0]           ram_din0_o,
  input  logic [31:0]           ram_dout0_i
);

  localparam logic [LatCntWidth-1:0] CntInit = LatCntWidth'(READ_LATENCY - 1);

  state_e                  state_q, state_d;
  logic [LatCntWidth-1:0]  cnt_q, cnt_d;
  logic                    ack_q, ack_d;
  logic [31:0]             dat_q, dat_d;
  logic                    csb_q, csb_d;
  logic                    web_q, web_d;
  logic [3:0]              wmask_q, wmask_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             din_q, din_d;
  logic                    hit;
  logic [ADDR_WIDTH-1:0]   word_adr;
`ifdef WB_OPENRAM_ERR_EN
  logic                    err_q, err_d;
  logic                    miss;
  assign miss = wbs_cyc_i & wbs_stb_i & ~hit;
`endif

  wb_openram_adr_dec #(
    .BASE_ADDR (BASE_ADDR),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_adr_dec (
    .cyc_i     (wbs_cyc_i),
    .stb_i     (wbs_stb_i),
    .adr_i     (wbs_adr_i),
    .hit_o     (hit),
    .word_adr_o(word_adr)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    dat_d   = dat_q;
    csb_d   = csb_q;
    web_d   = web_q;
    wmask_d = wmask_q;
    addr_d  = addr_q;
    din_d   = din_q;
`ifdef WB_OPENRAM_ERR_EN
    err_d   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (hit) begin
          state_d = StIssue;
          csb_d   = 1'b0;
          web_d   = ~wbs_we_i;
          wmask_d = wbs_we_i ? wbs_sel_i : 4'b0000;
          addr_d  = word_adr;
          din_d   = wbs_dat_i;
`ifdef WB_OPENRAM_ERR_EN
        end else if (miss && !err_q) begin
          // Gate on err_q so a held miss strobe yields discrete pulses.
          err_d = 1'b1;
`endif
        end
      end
      StIssue: begin
        csb_d = 1'b1;
        if (!wbs_cyc_i) begin
          state_d = StIdle;
        end else if (!web_q) begin
          state_d = StAck;
          ack_d   = 1'b1;
        end else begin
          state_d = StWait;
          cnt_d   = CntInit;
        end
      end
      StWait: begin
        if (!wbs_cyc_i) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d = StAck;
          ack_d   = 1'b1;
          dat_d   = ram_dout0_i;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      wmask_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
`ifdef WB_OPENRAM_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      wmask_q <= wmask_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
`ifdef WB_OPENRAM_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  assign wbs_ack_o    = ack_q;
  assign wbs_dat_o    = dat_q;
  assign ram_csb0_o   = csb_q;
  assign ram_web0_o   = web_q;
  assign ram_wmask0_o = wmask_q;
  assign ram_addr0_o  = addr_q;
  assign ram_din0_o   = din_q;
`ifdef WB_OPENRAM_ERR_EN
  assign wbs_err_o    = err_q;
`endif

endmodule

// File: tb/tb_wb_openram_ctrl.sv
// Directed bench for wb_openram_ctrl: behavioural macro, shadow memory and read-data scoreboard.
module tb_wb_openram_ctrl;
  import wb_openram_pkg::*;

  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cyc = 1'b0, stb = 1'b0, we_s = 1'b0;
  logic [3:0]    sel_s = '0;
  logic [31:0]   adr_s = '0, dat_s = '0;
  logic          ack;
  logic [31:0]   dat_o;
  logic          ram_csb, ram_web;
  logic [3:0]    ram_wmask;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_din;
  logic [31:0]   ram_dout = '0;
`ifdef WB_OPENRAM_ERR_EN
  logic          err;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem [256];
  logic [31:0] shadow [256];
  logic [AW-1:0] last_addr;
  logic [3:0]    last_wmask;
  logic [31:0]   last_din;
  logic          last_web;
  int lat, cl, nack;

  always #5 clk = ~clk;

  wb_openram_ctrl dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs_cyc_i   (cyc),
    .wbs_stb_i   (stb),
    .wbs_we_i    (we_s),
    .wbs_sel_i   (sel_s),
    .wbs_adr_i   (adr_s),
    .wbs_dat_i   (dat_s),
    .wbs_ack_o   (ack),
`ifdef WB_OPENRAM_ERR_EN
    .wbs_err_o   (err),
`endif
    .wbs_dat_o   (dat_o),
    .ram_csb0_o  (ram_csb),
    .ram_web0_o  (ram_web),
    .ram_wmask0_o(ram_wmask),
    .ram_addr0_o (ram_addr),
    .ram_din0_o  (ram_din),
    .ram_dout0_i (ram_dout)
  );

  // Behavioural 1rw macro, data valid one cycle after the sampling edge.
  always @(posedge clk) begin
    if (ram_csb == 1'b0) begin
      if (ram_web == 1'b0) begin
        for (int b = 0; b < 4; b++)
          if (ram_wmask[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
      end else begin
        ram_dout <= mem[ram_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle; returns edges until ack (0 = none) and csb-low cycle count.
  task automatic wb_cycle(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, output int lat_o, output int csb_low);
    logic [AW-1:0] wi;
    lat_o   = 0;
    csb_low = 0;
    wi      = adr[AW+1:2];
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we_s = we; adr_s = adr; dat_s = dat; sel_s = sel;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (ram_csb === 1'b0) begin
        csb_low++;
        last_addr = ram_addr; last_wmask = ram_wmask; last_din = ram_din; last_web = ram_web;
      end
      if (ack === 1'b1) begin
        lat_o = i;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0;
    if (lat_o != 0) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (sel[b]) shadow[wi][8*b +: 8] = dat[8*b +: 8];
      end else if (exp_q.size() > 0) begin
        chk("rd_data", dat_o, exp_q.pop_front());
      end else begin
        chk("rd_unexpected", 32'd1, 32'd0);
      end
    end
    @(posedge clk);
  endtask

  task automatic do_read(input logic [31:0] adr, output int lat_o, output int csb_low);
    logic [AW-1:0] wi;
    wi = adr[AW+1:2];
    exp_q.push_back(shadow[wi]);
    wb_cycle(1'b0, adr, 32'h0, 4'h0, lat_o, csb_low);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      shadow[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_csb", ram_csb, 1);
    chk("rst_web", ram_web, 1);
    chk("rst_wmask", ram_wmask, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_din", ram_din, 0);
    rst = 1'b0;

    // Full-word write.
    wb_cycle(1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, lat, cl);
    chk("t1_lat", lat, 2);
    chk("t1_csb_cycles", cl, 1);
    chk("t1_addr", last_addr, 8'h04);
    chk("t1_wmask", last_wmask, 4'hF);
    chk("t1_din", last_din, 32'hDEAD_BEEF);
    chk("t1_web", last_web, 0);
    chk("t1_dat_hold", dat_o, 0);

    // Read back.
    do_read(32'h3000_0010, lat, cl);
    chk("t2_lat", lat, 3);
    chk("t2_csb_cycles", cl, 1);
    chk("t2_web", last_web, 1);
    chk("t2_wmask", last_wmask, 0);
    chk("t2_dat_const", dat_o, 32'hDEAD_BEEF);

    // Byte-lane write, then read merged word.
    wb_cycle(1'b1, 32'h3000_0010, 32'h0000_AB00, 4'b0010, lat, cl);
    chk("t3_lat", lat, 2);
    chk("t3_wmask", last_wmask, 4'b0010);
    chk("t3_dat_hold", dat_o, 32'hDEAD_BEEF);
    do_read(32'h3000_0010, lat, cl);
    chk("t3_rd_lat", lat, 3);
    chk("t3_dat_const", dat_o, 32'hDEAD_ABEF);

    // sel=0 write pulses csb with empty mask and still acks.
    wb_cycle(1'b1, 32'h3000_0010, 32'hFFFF_FFFF, 4'b0000, lat, cl);
    chk("sel0_lat", lat, 2);
    chk("sel0_csb_cycles", cl, 1);
    chk("sel0_wmask", last_wmask, 0);
    do_read(32'h3000_0010, lat, cl);
    chk("sel0_rd_lat", lat, 3);

    // Last word of the window, issued back-to-back.
    wb_cycle(1'b1, 32'h3000_03FC, 32'h1234_5678, 4'hF, lat, cl);
    chk("top_lat", lat, 2);
    chk("top_addr", last_addr, 8'hFF);
    do_read(32'h3000_03FE, lat, cl);
    chk("top_rd_lat", lat, 3);

    // Misses just above and below the window.
    wb_cycle(1'b1, 32'h3000_0400, 32'hCAFE_F00D, 4'hF, lat, cl);
    chk("miss_hi_ack", lat, 0);
    chk("miss_hi_csb", cl, 0);
    wb_cycle(1'b0, 32'h2FFF_FFFC, 32'h0, 4'hF, lat, cl);
    chk("miss_lo_ack", lat, 0);
    chk("miss_lo_csb", cl, 0);
`ifdef WB_OPENRAM_ERR_EN
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we_s = 1'b0; adr_s = 32'h3000_0400;
    @(posedge clk); #1;
    chk("err_pulse", err, 1);
    chk("err_no_ack", ack, 0);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    chk("err_one_cycle", err, 0);
`endif

    // Abort a read in WAIT.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we_s = 1'b0; adr_s = 32'h3000_0010;
    @(posedge clk); #1;
    chk("abort_issue_csb", ram_csb, 0);
    @(posedge clk); #1;
    chk("abort_in_wait", dut.state_q, StWait);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    chk("abort_idle", dut.state_q, StIdle);
    nack = (ack === 1'b1) ? 1 : 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ack === 1'b1) nack++;
    end
    chk("abort_no_ack", nack, 0);
    wb_cycle(1'b1, 32'h3000_0020, 32'h0BAD_CAFE, 4'hF, lat, cl);
    chk("abort_next_lat", lat, 2);

    // Reset during ISSUE.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we_s = 1'b0; adr_s = 32'h3000_0020;
    @(posedge clk); #1;
    chk("rstmid_issue_csb", ram_csb, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_csb", ram_csb, 1);
    chk("rstmid_ack", ack, 0);
    chk("rstmid_dat", dat_o, 0);
    chk("rstmid_state", dut.state_q, StIdle);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    nack = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack === 1'b1) nack++;
    end
    chk("rstmid_no_ack", nack, 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
